// File: rtl/sevenseg_capture.sv
// Passive receiver for a multiplexed seven-segment bus: recovers the four scanned
// hex digits and publishes a frame once it has repeated STABLE_SCANS times.
module sevenseg_capture #(
    parameter int SETTLE       = 16,
    parameter int STABLE_SCANS = 2,
    parameter int TO_W         = 20
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [3:0]  anode,
    input  logic [7:0]  cathode,
    output logic [15:0] digits,
    output logic        digits_valid,
    output logic        update,
    output logic        bad_pattern,
    output logic        stalled
);

    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [3:0]      MATCH_MAX   = 4'(STABLE_SCANS);
    localparam logic [TO_W-1:0] STALL_MAX   = '1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

    // Returns {good, nibble}; segments are active-low in g..a order.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h40:   decode_seg = 5'h10;
            7'h79:   decode_seg = 5'h11;
            7'h24:   decode_seg = 5'h12;
            7'h30:   decode_seg = 5'h13;
            7'h19:   decode_seg = 5'h14;
            7'h12:   decode_seg = 5'h15;
            7'h02:   decode_seg = 5'h16;
            7'h78:   decode_seg = 5'h17;
            7'h00:   decode_seg = 5'h18;
            7'h10:   decode_seg = 5'h19;
            7'h08:   decode_seg = 5'h1A;
            7'h03:   decode_seg = 5'h1B;
            7'h46:   decode_seg = 5'h1C;
            7'h21:   decode_seg = 5'h1D;
            7'h06:   decode_seg = 5'h1E;
            7'h0E:   decode_seg = 5'h1F;
            default: decode_seg = 5'h00;
        endcase
    endfunction

    function automatic logic one_hot_low(input logic [3:0] a);
        return (a == 4'hE) || (a == 4'hD) || (a == 4'hB) || (a == 4'h7);
    endfunction

    function automatic logic [1:0] slot_of(input logic [3:0] a);
        case (a)
            4'hD:    slot_of = 2'd1;
            4'hB:    slot_of = 2'd2;
            4'h7:    slot_of = 2'd3;
            default: slot_of = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] match_sat_inc(input logic [3:0] m);
        return (m >= MATCH_MAX) ? MATCH_MAX : m + 4'd1;
    endfunction

    logic [3:0]      anode_p0, anode_p1, anode_prev;
    logic [6:0]      cathode_p0, cathode_p1;
    logic            unused_dp;
    state_t          state, state_nx;
    logic [7:0]      settle_cnt;
    logic [TO_W-1:0] stall_cnt;
    logic [15:0]     frame, prev_frame;
    logic [3:0]      seen, match;
    logic            err;

    logic            anode_chg, anode_ok, smp, good, err_set, complete, publish, stall_sat;
    logic [4:0]      dec;
    logic [1:0]      slot;
    logic [15:0]     frame_nx, prev_nx;
    logic [3:0]      seen_nx, match_nx;
    logic            err_nx;

    assign unused_dp = cathode[7];

    // Stage p0/p1: two-flop synchronizers on the display bus
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            anode_p0   <= 4'hF;
            anode_p1   <= 4'hF;
            anode_prev <= 4'hF;
            cathode_p0 <= 7'h7F;
            cathode_p1 <= 7'h7F;
        end else begin
            anode_p0   <= anode;
            anode_p1   <= anode_p0;
            anode_prev <= anode_p1;
            cathode_p0 <= cathode[6:0];
            cathode_p1 <= cathode_p0;
        end
    end

    assign anode_chg = (anode_p1 != anode_prev);
    assign anode_ok  = one_hot_low(anode_p1);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (anode_chg && anode_ok) state_nx = S_SETTLE;
            S_SETTLE: begin
                if (anode_chg)                       state_nx = anode_ok ? S_SETTLE : S_IDLE;
                else if (settle_cnt == SETTLE_LAST)  state_nx = S_HOLD;
            end
            S_HOLD:   if (anode_chg) state_nx = anode_ok ? S_SETTLE : S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        smp = (state == S_SETTLE) && !anode_chg && (settle_cnt == SETTLE_LAST);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)                         settle_cnt <= '0;
        else if (anode_chg)                 settle_cnt <= '0;
        else if (state == S_SETTLE && !smp) settle_cnt <= settle_cnt + 8'd1;
    end

    // Frame assembly: a bad sample still marks its slot so the frame can complete and be dropped
    always_comb begin
        dec       = decode_seg(cathode_p1);
        good      = dec[4];
        slot      = slot_of(anode_p1);
        frame_nx  = frame;
        if (smp && good) frame_nx[{slot, 2'b00} +: 4] = dec[3:0];
        seen_nx   = seen | (smp ? (4'b0001 << slot) : 4'b0000);
        err_set   = err || (smp && !good);
        err_nx    = err_set;
        complete  = smp && (seen_nx == 4'hF);
        stall_sat = (stall_cnt == STALL_MAX) && !anode_chg;
        match_nx  = match;
        prev_nx   = prev_frame;
        publish   = 1'b0;
        if (complete) begin
            seen_nx = '0;
            err_nx  = 1'b0;
            if (err_set) begin
                match_nx = '0;
            end else if (frame_nx == prev_frame) begin
                match_nx = match_sat_inc(match);
            end else begin
                prev_nx  = frame_nx;
                match_nx = 4'd1;
            end
            publish = !err_set && (match_nx == MATCH_MAX);
        end
        if (stall_sat) begin
            seen_nx  = '0;
            err_nx   = 1'b0;
            match_nx = '0;
            publish  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            frame      <= '0;
            prev_frame <= '0;
            seen       <= '0;
            match      <= '0;
            err        <= 1'b0;
        end else begin
            frame      <= frame_nx;
            prev_frame <= prev_nx;
            seen       <= seen_nx;
            match      <= match_nx;
            err        <= err_nx;
        end
    end

    // Stall watchdog: an anode change always beats saturation
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            stall_cnt <= '0;
            stalled   <= 1'b0;
        end else if (anode_chg) begin
            stall_cnt <= '0;
            stalled   <= 1'b0;
        end else begin
            if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + 1'b1;
            if (stall_sat)              stalled   <= 1'b1;
        end
    end

    // Output stage: registered together one cycle after the completing sample
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            digits       <= '0;
            digits_valid <= 1'b0;
            update       <= 1'b0;
            bad_pattern  <= 1'b0;
        end else begin
            bad_pattern <= smp && !good;
            update      <= publish && (!digits_valid || (frame_nx != digits));
            if (publish) begin
                digits       <= frame_nx;
                digits_valid <= 1'b1;
            end else if (stall_sat) begin
                digits_valid <= 1'b0;
            end
        end
    end

endmodule
